// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants and the padder state encoding.
package sha256_pkg;

  localparam int unsigned BLOCK_W      = 512;
  localparam int unsigned WORD_W       = 32;
  localparam int unsigned NUM_WORDS    = BLOCK_W / WORD_W;
  localparam int unsigned LEN_BYTE_POS = 56;
  localparam logic [7:0]  PAD_BYTE     = 8'h80;

  // H(0) for SHA-256, word 0 in the top bits.
  localparam logic [255:0] INITIAL_HASH = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StPad,
    StExtra,
    StIssue,
    StHold,
    StWaitDone
  } pad_state_e;

endpackage

// File: rtl/sha256_pad_mask.sv
// Final-word masking: keeps the first nbytes bytes, drops the 0x80 marker right after them and
// zeros the rest. A full word (nbytes >= 4) passes through with no marker placed.
module sha256_pad_mask
  import sha256_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  input  logic [2:0]        nbytes,
  output logic [WORD_W-1:0] masked,
  output logic              pad_placed
);

  // Select the surviving bytes and the marker position from the valid byte count.
  always_comb begin
    masked     = '0;
    pad_placed = 1'b1;
    case (nbytes)
      3'd0:    masked = {PAD_BYTE, 24'h000000};
      3'd1:    masked = {word[31:24], PAD_BYTE, 16'h0000};
      3'd2:    masked = {word[31:16], PAD_BYTE, 8'h00};
      3'd3:    masked = {word[31:8], PAD_BYTE};
      default: begin
        masked     = word;
        pad_placed = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/sha256_padder.sv
// Message word stream -> padded 512-bit blocks for the SHA-256 core, paced by core pause/done.
module sha256_padder
  import sha256_pkg::*;
#(
  parameter int unsigned LEN_W = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORD_W-1:0]  in_data,
  input  logic               in_last,
  input  logic [2:0]         in_nbytes,
  input  logic               core_pause,
  input  logic               core_done,
  output logic               blk_valid,
  output logic               blk_last,
  output logic [BLOCK_W-1:0] blk_data,
  output logic               busy
);

  pad_state_e        state_q;
  logic [WORD_W-1:0] blk_buf_q [NUM_WORDS];
  logic [3:0]        idx_q;
  logic [LEN_W-1:0]  len_q;
  logic [5:0]        p_q;        // byte position right after the last message byte
  logic              pad_done_q; // 0x80 marker already written for this message
  logic              last_f_q;
  logic              extra_q;    // a length-only block must follow the current one
  logic              blk_valid_q;
  logic              blk_last_q;

  logic [2:0]        nb_eff;
  logic [WORD_W-1:0] last_word;
  logic              pad_placed;
  logic [63:0]       len64;

  // Out-of-range byte counts are treated as a full word.
  assign nb_eff = (in_nbytes > 3'd4) ? 3'd4 : in_nbytes;
  assign len64  = 64'(len_q);

  sha256_pad_mask u_pad_mask (
    .word       (in_data),
    .nbytes     (nb_eff),
    .masked     (last_word),
    .pad_placed (pad_placed)
  );

  // Padder FSM: word capture, padding, block issue and core handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      len_q       <= '0;
      p_q         <= '0;
      pad_done_q  <= 1'b0;
      last_f_q    <= 1'b0;
      extra_q     <= 1'b0;
      blk_valid_q <= 1'b0;
      blk_last_q  <= 1'b0;
      for (int i = 0; i < NUM_WORDS; i++) blk_buf_q[i] <= '0;
    end else begin
      blk_valid_q <= 1'b0;
      blk_last_q  <= 1'b0;
      unique case (state_q)
        StIdle: state_q <= StFill;
        StFill: begin
          if (in_valid) begin
            // First word of a block wipes the previous block so no stale words survive.
            if (idx_q == 4'd0) begin
              for (int i = 0; i < NUM_WORDS; i++) blk_buf_q[i] <= '0;
            end
            blk_buf_q[idx_q] <= in_last ? last_word : in_data;
            idx_q <= idx_q + 4'd1;
            if (in_last) begin
              len_q      <= len_q + LEN_W'({nb_eff, 3'b000});
              p_q        <= {idx_q, 2'b00} + 6'(nb_eff);
              pad_done_q <= pad_placed;
              if (idx_q == 4'd15 && !pad_placed) begin
                last_f_q <= 1'b0;
                extra_q  <= 1'b1;
                state_q  <= StIssue;
              end else begin
                state_q <= StPad;
              end
            end else begin
              len_q <= len_q + LEN_W'(WORD_W);
              if (idx_q == 4'd15) begin
                last_f_q <= 1'b0;
                extra_q  <= 1'b0;
                state_q  <= StIssue;
              end
            end
          end
        end
        StPad: begin
          // A full final word leaves the marker for the start of the next word.
          if (!pad_done_q) blk_buf_q[p_q[5:2]][31:24] <= PAD_BYTE;
          pad_done_q <= 1'b1;
          if (p_q < 6'(LEN_BYTE_POS)) begin
            blk_buf_q[NUM_WORDS-2] <= len64[63:32];
            blk_buf_q[NUM_WORDS-1] <= len64[31:0];
            last_f_q <= 1'b1;
            extra_q  <= 1'b0;
          end else begin
            last_f_q <= 1'b0;
            extra_q  <= 1'b1;
          end
          state_q <= StIssue;
        end
        StExtra: begin
          for (int i = 1; i < NUM_WORDS - 2; i++) blk_buf_q[i] <= '0;
          blk_buf_q[0]           <= pad_done_q ? '0 : {PAD_BYTE, 24'h000000};
          blk_buf_q[NUM_WORDS-2] <= len64[63:32];
          blk_buf_q[NUM_WORDS-1] <= len64[31:0];
          pad_done_q <= 1'b1;
          last_f_q   <= 1'b1;
          extra_q    <= 1'b0;
          state_q    <= StIssue;
        end
        StIssue: begin
          if (!core_pause) begin
            blk_valid_q <= 1'b1;
            blk_last_q  <= last_f_q;
            state_q     <= last_f_q ? StWaitDone : StHold;
          end
        end
        StHold: begin
          // One dead cycle lets the core raise pause before the next block is offered.
          if (extra_q) begin
            state_q <= StExtra;
          end else begin
            idx_q   <= '0;
            state_q <= StFill;
          end
        end
        StWaitDone: begin
          if (core_done) begin
            len_q   <= '0;
            idx_q   <= '0;
            state_q <= StFill;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_WORDS; g++) begin : g_blk_data
    assign blk_data[BLOCK_W-1-WORD_W*g -: WORD_W] = blk_buf_q[g];
  end

  assign in_ready  = (state_q == StFill);
  assign blk_valid = blk_valid_q;
  assign blk_last  = blk_last_q;
  // Sitting in FILL with nothing accepted yet is the only non-idle quiet point.
  assign busy      = (state_q != StIdle) &&
                     !(state_q == StFill && idx_q == 4'd0 && len_q == '0);

endmodule

// File: tb/tb_sha256_padder.sv
// Self-checking bench for sha256_padder with a byte-level padding reference model.
module tb_sha256_padder;
  import sha256_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, in_last, core_pause, core_done;
  logic         blk_valid, blk_last, busy;
  logic [31:0]  in_data;
  logic [2:0]   in_nbytes;
  logic [511:0] blk_data;

  logic auto_core, emu_pause, emu_done, man_pause, man_done;
  assign core_pause = auto_core ? emu_pause : man_pause;
  assign core_done  = auto_core ? emu_done  : man_done;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;

  logic [7:0]   msg[$];
  logic [512:0] got[$];
  logic [512:0] exp_q[$];

  typedef struct {
    int          nbytes;
    int          exp_blocks;
    logic [63:0] exp_bits;
  } vec_t;
  vec_t vecs[9];

  always #5 clk = ~clk;

  sha256_padder #(.LEN_W(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_nbytes  (in_nbytes),
    .core_pause (core_pause),
    .core_done  (core_done),
    .blk_valid  (blk_valid),
    .blk_last   (blk_last),
    .blk_data   (blk_data),
    .busy       (busy)
  );

  // Block capture.
  always @(negedge clk) if (blk_valid === 1'b1) got.push_back({blk_last, blk_data});

  // Core stand-in: pause after a non-last block, done some cycles after the last one.
  initial begin
    emu_pause = 1'b0;
    emu_done  = 1'b0;
    forever begin
      @(negedge clk);
      if (auto_core && blk_valid === 1'b1) begin
        if (!blk_last) begin
          emu_pause = 1'b1;
          repeat ($urandom_range(1, 8)) @(negedge clk);
          emu_pause = 1'b0;
        end else begin
          repeat ($urandom_range(1, 10)) @(negedge clk);
          emu_done = 1'b1;
          @(negedge clk);
          emu_done = 1'b0;
          done_cnt++;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no end of test, required finish before time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [512:0] act, input logic [512:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  function automatic logic [31:0] word_of(input logic [512:0] b, input int i);
    return b[511-32*i -: 32];
  endfunction

  function automatic logic [512:0] got_blk(input int i);
    if (i < got.size()) return got[i];
    return '0;
  endfunction

  task automatic set_msg(input int n, input bit rnd);
    msg.delete();
    for (int i = 0; i < n; i++) msg.push_back(rnd ? 8'($urandom) : 8'(i * 7 + n + 1));
  endtask

  // Reference: append 0x80, zero to 56 mod 64, then the 64-bit bit count; cut into blocks.
  task automatic build_expected(input int n);
    logic [7:0]   p[$];
    logic [63:0]  bits;
    logic [511:0] d;
    int           nblk;
    exp_q.delete();
    p = msg;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bits = 64'(n) * 64'd8;
    for (int k = 7; k >= 0; k--) p.push_back(bits[8*k +: 8]);
    nblk = p.size() / 64;
    for (int b = 0; b < nblk; b++) begin
      for (int j = 0; j < 64; j++) d[511-8*j -: 8] = p[64*b+j];
      exp_q.push_back({(b == nblk - 1), d});
    end
  endtask

  task automatic send_msg(input int n, input bit gaps, input int stop_after);
    int nw, nb, tmo;
    logic [31:0] w32;
    nw = (n == 0) ? 1 : (n + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      if (stop_after >= 0 && w >= stop_after) break;
      if (gaps) while ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      nb = (w == nw - 1) ? n - 4 * w : 4;
      for (int b = 0; b < 4; b++)
        w32[31-8*b -: 8] = (4 * w + b < n) ? msg[4*w+b] : 8'($urandom);
      in_data   = w32;
      in_last   = (w == nw - 1) && (stop_after < 0);
      in_nbytes = 3'(nb);
      in_valid  = 1'b1;
      tmo = 0;
      while (in_ready !== 1'b1 && tmo < 500) begin
        @(negedge clk);
        tmo++;
      end
      if (tmo >= 500) begin
        check("in_ready timeout", 513'(in_ready), 513'(1));
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_msg(input int n, input bit gaps, input string tag, output int base);
    int start, tmo;
    base  = got.size();
    start = done_cnt;
    build_expected(n);
    send_msg(n, gaps, -1);
    tmo = 0;
    while (done_cnt == start && tmo < 3000) begin
      @(negedge clk);
      tmo++;
    end
    check({tag, " core_done reached"}, 513'(done_cnt != start), 513'(1));
    @(negedge clk);
    check({tag, " busy idle"}, 513'(busy), 513'(0));
    check({tag, " block count"}, 513'(got.size() - base), 513'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s block %0d", tag, i), got_blk(base + i), exp_q[i]);
  endtask

  initial begin
    int base;
    int n;
    logic [512:0] a, b;
    logic [511:0] snap;
    bit stable, quiet, held;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_nbytes = '0;
    auto_core = 1'b1; man_pause = 1'b0; man_done = 1'b0;

    vecs[0] = '{0,   1, 64'd0};
    vecs[1] = '{3,   1, 64'd24};
    vecs[2] = '{55,  1, 64'd440};
    vecs[3] = '{56,  2, 64'd448};
    vecs[4] = '{63,  2, 64'd504};
    vecs[5] = '{64,  2, 64'd512};
    vecs[6] = '{119, 2, 64'd952};
    vecs[7] = '{120, 3, 64'd960};
    vecs[8] = '{128, 3, 64'd1024};

    repeat (3) @(negedge clk);
    check("reset in_ready", 513'(in_ready), 513'(0));
    check("reset blk_valid", 513'(blk_valid), 513'(0));
    check("reset blk_last", 513'(blk_last), 513'(0));
    check("reset blk_data", 513'(blk_data), 513'(0));
    check("reset busy", 513'(busy), 513'(0));
    rst_n = 1'b1;

    // Length table.
    foreach (vecs[v]) begin
      set_msg(vecs[v].nbytes, 1'b0);
      run_msg(vecs[v].nbytes, 1'b0, $sformatf("len%0d", vecs[v].nbytes), base);
      check($sformatf("len%0d table blocks", vecs[v].nbytes),
            513'(got.size() - base), 513'(vecs[v].exp_blocks));
      a = got_blk(base + vecs[v].exp_blocks - 1);
      check($sformatf("len%0d table bit count", vecs[v].nbytes), 513'(a[63:0]),
            513'(vecs[v].exp_bits));
    end

    // "abc" with garbage in the unused byte.
    msg = '{8'h61, 8'h62, 8'h63};
    run_msg(3, 1'b0, "abc", base);
    a = got_blk(base);
    check("abc word0", 513'(word_of(a, 0)), 513'(32'h61626380));
    check("abc word15", 513'(word_of(a, 15)), 513'(32'h00000018));
    check("abc words1-14 zero", 513'(a[479:32]), 513'(0));
    check("abc last flag", 513'(a[512]), 513'(1));

    // 56 bytes: marker at byte 56, length in a second block.
    set_msg(56, 1'b1);
    run_msg(56, 1'b0, "m56", base);
    a = got_blk(base);
    b = got_blk(base + 1);
    check("m56 A word14", 513'(word_of(a, 14)), 513'(32'h80000000));
    check("m56 A word15", 513'(word_of(a, 15)), 513'(0));
    check("m56 A last", 513'(a[512]), 513'(0));
    check("m56 B zeros", 513'(b[511:32]), 513'(0));
    check("m56 B len", 513'(word_of(b, 15)), 513'(32'h1C0));
    check("m56 B last", 513'(b[512]), 513'(1));

    // 64 bytes: marker opens the extra block.
    set_msg(64, 1'b1);
    run_msg(64, 1'b0, "m64", base);
    a = got_blk(base);
    b = got_blk(base + 1);
    check("m64 A last", 513'(a[512]), 513'(0));
    check("m64 B word0", 513'(word_of(b, 0)), 513'(32'h80000000));
    check("m64 B middle zero", 513'(b[479:32]), 513'(0));
    check("m64 B len", 513'(word_of(b, 15)), 513'(32'h200));
    check("m64 B last", 513'(b[512]), 513'(1));

    // Pause held at ISSUE; a stray core_done is ignored there.
    auto_core = 1'b0;
    man_pause = 1'b1;
    msg = '{8'h61, 8'h62, 8'h63};
    base = got.size();
    send_msg(3, 1'b0, -1);
    repeat (3) @(negedge clk);
    snap = blk_data; stable = 1'b1; quiet = 1'b1; held = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (blk_data !== snap) stable = 1'b0;
      if (blk_valid !== 1'b0) quiet = 1'b0;
      if (busy !== 1'b1) held = 1'b0;
      if (i == 30) man_done = 1'b1;
      if (i == 31) man_done = 1'b0;
    end
    check("pause blk_data stable", 513'(stable), 513'(1));
    check("pause no blk_valid", 513'(quiet), 513'(1));
    check("pause busy held", 513'(held), 513'(1));
    check("pause block word0", 513'(snap[511:480]), 513'(32'h61626380));
    check("pause block word15", 513'(snap[31:0]), 513'(32'h18));
    man_pause = 1'b0;
    @(negedge clk);
    check("pause release blk_valid", 513'(blk_valid), 513'(1));
    check("pause release blk_last", 513'(blk_last), 513'(1));
    @(negedge clk);
    check("pause pulse width", 513'(blk_valid), 513'(0));
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    @(negedge clk);
    check("pause done busy", 513'(busy), 513'(0));
    check("pause block count", 513'(got.size() - base), 513'(1));
    auto_core = 1'b1;

    // Reset mid-message after 7 words.
    set_msg(40, 1'b0);
    base = got.size();
    send_msg(40, 1'b0, 7);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset in_ready", 513'(in_ready), 513'(0));
    check("midreset blk_valid", 513'(blk_valid), 513'(0));
    check("midreset blk_data", 513'(blk_data), 513'(0));
    check("midreset busy", 513'(busy), 513'(0));
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midreset nothing emitted", 513'(got.size() - base), 513'(0));
    msg = '{8'h61, 8'h62, 8'h63};
    run_msg(3, 1'b0, "abc after reset", base);
    a = got_blk(base);
    check("abc after reset word0", 513'(word_of(a, 0)), 513'(32'h61626380));
    check("abc after reset word15", 513'(word_of(a, 15)), 513'(32'h18));

    // Random lengths, random content, random input gaps.
    for (int r = 0; r < 25; r++) begin
      n = $urandom_range(0, 200);
      set_msg(n, 1'b1);
      run_msg(n, 1'b1, $sformatf("rand%0d len%0d", r, n), base);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
